// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Transmit-side scheduler for a 4x4 systolic array. Holds operand
//   matrices A and B, loaded row-wise while idle. On start, it drives
//   diagonally skewed, reverse-ordered operand streams on the west and
//   north array inputs. It then drives a zero drain window and pulses done.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   wr_en        load one matrix row (honoured only while idle)
//   wr_sel       0 = matrix A, 1 = matrix B
//   wr_row       row index 0..3
//   wr_data      row elements, element c at [c*DATA_W +: DATA_W]
//   start        begin a feed sequence (sampled only while idle)
//   busy         high in FEED, DRAIN and DONE
//   feed_valid   high during the 7 feed steps
//   done         one-cycle pulse at end of sequence
//   inp_west*    west operands for array rows 0..3
//   inp_north*   north operands for array columns 0..3
module systolic_feeder #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                wr_sel,
    input  logic [1:0]          wr_row,
    input  logic [4*DATA_W-1:0] wr_data,
    input  logic                start,
    output logic                busy,
    output logic                feed_valid,
    output logic                done,
    output logic [DATA_W-1:0]   inp_west0,
    output logic [DATA_W-1:0]   inp_west4,
    output logic [DATA_W-1:0]   inp_west8,
    output logic [DATA_W-1:0]   inp_west12,
    output logic [DATA_W-1:0]   inp_north0,
    output logic [DATA_W-1:0]   inp_north1,
    output logic [DATA_W-1:0]   inp_north2,
    output logic [DATA_W-1:0]   inp_north3
);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t            state_q, state_d;
    logic [2:0]        step_q, step_d;
    logic [3:0]        drain_q, drain_d;
    logic [DATA_W-1:0] a_q [4][4];
    logic [DATA_W-1:0] a_d [4][4];
    logic [DATA_W-1:0] b_q [4][4];
    logic [DATA_W-1:0] b_d [4][4];
    logic              busy_q, busy_d;
    logic              feed_valid_q, feed_valid_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] west_q [4];
    logic [DATA_W-1:0] west_d [4];
    logic [DATA_W-1:0] north_q [4];
    logic [DATA_W-1:0] north_d [4];

    // State, counters, storage and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            step_q       <= '0;
            drain_q      <= '0;
            busy_q       <= 1'b0;
            feed_valid_q <= 1'b0;
            done_q       <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                west_q[i]  <= '0;
                north_q[i] <= '0;
                for (int unsigned j = 0; j < 4; j++) begin
                    a_q[i][j] <= '0;
                    b_q[i][j] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            drain_q      <= drain_d;
            busy_q       <= busy_d;
            feed_valid_q <= feed_valid_d;
            done_q       <= done_d;
            west_q       <= west_d;
            north_q      <= north_d;
            a_q          <= a_d;
            b_q          <= b_d;
        end
    end

    // Next-state and counters
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FEED;
                    step_d  = '0;
                end
            end
            S_FEED: begin
                if (step_q == 3'd6) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                step_d  = '0;
                drain_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Row loads, accepted only while idle
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (state_q == S_IDLE && wr_en) begin
            for (int unsigned c = 0; c < 4; c++) begin
                if (wr_sel) begin
                    b_d[wr_row][2'(c)] = wr_data[c*DATA_W +: DATA_W];
                end else begin
                    a_d[wr_row][2'(c)] = wr_data[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Outputs are computed from next state and next storage, then registered.
    // This makes step t visible in the cycle after edge E0+t. It also lets a
    // row written on the start edge reach step 0.
    always_comb begin
        logic [1:0] idx;
        idx          = '0;
        busy_d       = (state_d != S_IDLE);
        feed_valid_d = (state_d == S_FEED);
        done_d       = (state_d == S_DONE);
        for (int unsigned i = 0; i < 4; i++) begin
            west_d[i]  = '0;
            north_d[i] = '0;
            if (state_d == S_FEED && 32'(step_d) >= i && 32'(step_d) <= i + 3) begin
                idx        = 2'(3 + i - 32'(step_d));
                west_d[i]  = a_d[2'(i)][idx];
                north_d[i] = b_d[idx][2'(i)];
            end
        end
    end

    assign busy       = busy_q;
    assign feed_valid = feed_valid_q;
    assign done       = done_q;
    assign inp_west0  = west_q[0];
    assign inp_west4  = west_q[1];
    assign inp_west8  = west_q[2];
    assign inp_west12 = west_q[3];
    assign inp_north0 = north_q[0];
    assign inp_north1 = north_q[1];
    assign inp_north2 = north_q[2];
    assign inp_north3 = north_q[3];

endmodule
